// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI register-bank peripheral.
package spi_pkg;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, HOLD} spi_state_e;

  localparam logic SPI_WRITE = 1'b1;
  localparam logic SPI_READ  = 1'b0;

  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with rise/fall detection
// on the synchronised level.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_sig,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // NOTE: non-blocking assignments so each stage captures the previous stage's old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_sig};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_regbank_peripheral.sv
// SPI mode-0 register bank: RW + address + data frames, write commit on
// chip-select release, read-back over cipo, frame-length error pulse.
module spi_regbank_peripheral
  import spi_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ncs,
  input  logic                         sclk,
  input  logic                         copi,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         frame_err
);

  localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_FRAME    = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_ADDR_END = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_DATA_END = CNT_W'(ADDR_W + DATA_W);
  localparam logic [CNT_W-1:0] CNT_DATA_1ST = CNT_W'(ADDR_W + 1);

  logic ncs_s, cs_rise, cs_fall;
  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic copi_s, copi_rise_unused, copi_fall_unused;

  // ncs resets to "selected" so a frame already in progress at reset release
  // produces no cs_fall and is never resumed.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_ncs (
    .clk(clk), .rst_n(rst_n), .async_sig(ncs),
    .level(ncs_s), .rise(cs_rise), .fall(cs_fall));

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .async_sig(sclk),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall));

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_copi (
    .clk(clk), .rst_n(rst_n), .async_sig(copi),
    .level(copi_s), .rise(copi_rise_unused), .fall(copi_fall_unused));

  logic sel_rise, sel_fall;
  assign sel_rise = sclk_rise & ~ncs_s;
  assign sel_fall = sclk_fall & ~ncs_s;

  spi_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                rw_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   shift_q;
  logic                load_q;
  logic [DATA_W-1:0]   reg_q [NUM_REGS];
  logic [DATA_W-1:0]   rd_val;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (addr_q == ADDR_W'(i)) rd_val = reg_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rw_q      <= SPI_READ;
      addr_q    <= '0;
      data_q    <= '0;
      shift_q   <= '0;
      load_q    <= 1'b0;
      cipo_oe   <= 1'b0;
      wr_strobe <= '0;
      frame_err <= 1'b0;
      // NOTE: the register array is reset explicitly; downstream logic relies on all-zero regs after reset.
      for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= '0;
    end else begin
      wr_strobe <= '0;
      frame_err <= 1'b0;
      load_q    <= 1'b0;
      if (load_q) shift_q <= rd_val;

      if (state_q != IDLE && cs_rise) begin
        state_q <= IDLE;
        cipo_oe <= 1'b0;
        if (cnt_q != CNT_FRAME) begin
          frame_err <= 1'b1;
        end else if (rw_q == SPI_WRITE) begin
          for (int i = 0; i < NUM_REGS; i++)
            if (addr_q == ADDR_W'(i)) begin
              reg_q[i]     <= data_q;
              wr_strobe[i] <= 1'b1;
            end
        end
      end else if (state_q == IDLE) begin
        if (cs_fall) begin
          state_q <= CMD;
          cipo_oe <= 1'b1;
          cnt_q   <= '0;
          rw_q    <= SPI_READ;
          addr_q  <= '0;
          data_q  <= '0;
          shift_q <= '0;
        end
      end else begin
        if (sel_rise) begin
          if (cnt_q != CNT_SAT) cnt_q <= cnt_q + CNT_W'(1);
          case (state_q)
            CMD: begin
              rw_q    <= copi_s;
              state_q <= ADDR;
            end
            ADDR: begin
              addr_q <= {addr_q[ADDR_W-2:0], copi_s};
              if (cnt_q == CNT_ADDR_END) begin
                state_q <= DATA;
                load_q  <= 1'b1;
              end
            end
            DATA: begin
              data_q <= {data_q[DATA_W-2:0], copi_s};
              if (cnt_q == CNT_DATA_END) state_q <= HOLD;
            end
            default: ;
          endcase
        end
        // The fall closing the last address bit precedes the MSB's sampling
        // edge, so shifting starts only after the first data bit is sampled.
        if (sel_fall && state_q == DATA && cnt_q > CNT_DATA_1ST)
          shift_q <= {shift_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign cipo = (state_q == DATA && rw_q == SPI_READ) ? shift_q[DATA_W-1] : 1'b0;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[g*DATA_W +: DATA_W] = reg_q[g];
  end

endmodule

// File: tb/tb_spi_regbank_peripheral.sv
// Self-checking bench: directed frames plus randomized frames against an
// array model of the register bank.
module tb_spi_regbank_peripheral;

  localparam int NUM_REGS = 5;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ncs = 1'b1;
  logic sclk = 1'b0;
  logic copi = 1'b0;
  logic cipo, cipo_oe, frame_err;
  logic [NUM_REGS*DATA_W-1:0] regs;
  logic [NUM_REGS-1:0] wr_strobe;

  spi_regbank_peripheral #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ncs(ncs), .sclk(sclk), .copi(copi),
    .cipo(cipo), .cipo_oe(cipo_oe), .regs(regs), .wr_strobe(wr_strobe), .frame_err(frame_err));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: register contents as plain bytes.
  logic [DATA_W-1:0] model [NUM_REGS];

  function automatic logic [NUM_REGS*DATA_W-1:0] model_flat();
    logic [NUM_REGS*DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) v[i*DATA_W +: DATA_W] = model[i];
    return v;
  endfunction

  // Output monitor.
  int strobe_cnt = 0, err_cnt = 0, oe_bad = 0, cipo_bad = 0, onehot_bad = 0;
  int ncs_hi_run = 0, ncs_lo_run = 0;
  int strobe_q[$];
  logic cur_write = 1'b0;
  logic frame_live = 1'b0;

  always @(negedge clk) begin
    ncs_hi_run <= ncs ? ncs_hi_run + 1 : 0;
    ncs_lo_run <= ncs ? 0 : ncs_lo_run + 1;
    if (rst_n) begin
      if ($countones(wr_strobe) > 1) onehot_bad <= onehot_bad + 1;
      strobe_cnt <= strobe_cnt + $countones(wr_strobe);
      for (int i = 0; i < NUM_REGS; i++) if (wr_strobe[i]) strobe_q.push_back(i);
      if (frame_err) err_cnt <= err_cnt + 1;
      if (ncs_hi_run >= 4 && (cipo_oe || cipo)) oe_bad <= oe_bad + 1;
      if (ncs_lo_run >= 4 && frame_live && !cipo_oe) oe_bad <= oe_bad + 1;
      if (cur_write && cipo) cipo_bad <= cipo_bad + 1;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame; half is the SCLK half-period in clk cycles.
  task automatic send_frame(input logic rw, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                            input int nbits, input int half, input int rst_at, input int gap,
                            output logic [DATA_W-1:0] rx);
    logic [15:0] fr;
    fr = {rw, addr, data};
    rx = '0;
    cur_write = rw;
    frame_live = 1'b1;
    ncs = 1'b0;
    wait_clks(half);
    for (int b = 0; b < nbits; b++) begin
      if (b == rst_at) begin
        rst_n = 1'b0;
        frame_live = 1'b0;
        wait_clks(2);
        rst_n = 1'b1;
      end
      copi = (b < 16) ? fr[15-b] : 1'b0;
      wait_clks(half);
      sclk = 1'b1;
      if (b >= 8 && b < 16) rx = {rx[DATA_W-2:0], cipo};
      wait_clks(half);
      sclk = 1'b0;
    end
    wait_clks(half);
    ncs = 1'b1;
    copi = 1'b0;
    frame_live = 1'b0;
    cur_write = 1'b0;
    wait_clks(gap);
  endtask

  // One frame with full bookkeeping against the model.
  task automatic run_frame(input logic rw, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                           input int nbits, input int half, input string tag);
    int s0, e0;
    logic [DATA_W-1:0] rx, exp_rx;
    bit in_range, commit;
    s0 = strobe_cnt;
    e0 = err_cnt;
    strobe_q.delete();
    in_range = int'(addr) < NUM_REGS;
    exp_rx = in_range ? model[addr] : '0;
    send_frame(rw, addr, data, nbits, half, -1, 10, rx);
    commit = (nbits == 16) && rw && in_range;
    if (commit) model[addr] = data;
    check($sformatf("%s strobes", tag), 64'(strobe_cnt - s0), 64'(commit));
    if (commit && strobe_q.size() > 0) check($sformatf("%s strobe idx", tag), 64'(strobe_q[0]), 64'(addr));
    check($sformatf("%s frame_err", tag), 64'(err_cnt - e0), 64'(nbits != 16));
    if (!rw && nbits == 16) check($sformatf("%s read data", tag), 64'(rx), 64'(exp_rx));
    check($sformatf("%s regs", tag), 64'(regs), 64'(model_flat()));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] rx;
    int s0, e0;
    int halves [3] = '{4, 5, 8};

    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    wait_clks(3);
    check("reset regs", 64'(regs), 64'(0));
    check("reset wr_strobe", 64'(wr_strobe), 64'(0));
    check("reset frame_err", 64'(frame_err), 64'(0));
    check("reset cipo", 64'(cipo), 64'(0));
    check("reset cipo_oe", 64'(cipo_oe), 64'(0));
    rst_n = 1'b1;
    wait_clks(4);

    run_frame(1'b1, 7'd0, 8'hA5, 16, 4, "wr a0");
    run_frame(1'b1, 7'd4, 8'h3C, 16, 4, "wr a4");
    run_frame(1'b0, 7'd4, 8'h00, 16, 4, "rd a4");
    run_frame(1'b1, 7'd9, 8'hFF, 16, 4, "wr a9");
    run_frame(1'b0, 7'd9, 8'h00, 16, 4, "rd a9");
    run_frame(1'b1, 7'd1, 8'h55, 12, 4, "short12");
    run_frame(1'b1, 7'd1, 8'h55, 17, 4, "long17");

    // Reset in the middle of a write: frame lost, bank cleared.
    s0 = strobe_cnt;
    e0 = err_cnt;
    send_frame(1'b1, 7'd2, 8'h77, 16, 4, 10, 10, rx);
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    check("rst mid strobes", 64'(strobe_cnt - s0), 64'(0));
    check("rst mid frame_err", 64'(err_cnt - e0), 64'(0));
    check("rst mid regs", 64'(regs), 64'(0));
    run_frame(1'b1, 7'd2, 8'h11, 16, 4, "wr a2 after rst");

    // Back-to-back writes with a 2-cycle chip-select gap, at each clock ratio.
    foreach (halves[k]) begin
      s0 = strobe_cnt;
      e0 = err_cnt;
      strobe_q.delete();
      send_frame(1'b1, 7'd3, 8'h81 + 8'(k), 16, halves[k], -1, 2, rx);
      send_frame(1'b1, 7'd2, 8'h42 + 8'(k), 16, halves[k], -1, 10, rx);
      model[3] = 8'h81 + 8'(k);
      model[2] = 8'h42 + 8'(k);
      check($sformatf("b2b r%0d strobes", 2*halves[k]), 64'(strobe_cnt - s0), 64'(2));
      if (strobe_q.size() == 2) begin
        check($sformatf("b2b r%0d first", 2*halves[k]), 64'(strobe_q[0]), 64'(3));
        check($sformatf("b2b r%0d second", 2*halves[k]), 64'(strobe_q[1]), 64'(2));
      end
      check($sformatf("b2b r%0d frame_err", 2*halves[k]), 64'(err_cnt - e0), 64'(0));
      check($sformatf("b2b r%0d regs", 2*halves[k]), 64'(regs), 64'(model_flat()));
    end

    // Randomized frames.
    for (int n = 0; n < 40; n++) begin
      logic rw;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      int nbits, half;
      int lens [4] = '{10, 15, 17, 18};
      rw    = 1'($urandom_range(0, 1));
      addr  = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, 127)) : ADDR_W'($urandom_range(0, NUM_REGS-1));
      data  = DATA_W'($urandom);
      nbits = ($urandom_range(0, 4) == 0) ? lens[$urandom_range(0, 3)] : 16;
      half  = halves[$urandom_range(0, 2)];
      run_frame(rw, addr, data, nbits, half, $sformatf("rand%0d", n));
    end

    check("strobe one-hot", 64'(onehot_bad), 64'(0));
    check("cipo_oe window", 64'(oe_bad), 64'(0));
    check("cipo quiet on writes", 64'(cipo_bad), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
